// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its environment.
// slave  : the sequencer (samples lock/restart, drives reset and status)
// master : the board-level controller or bench (drives lock/restart)
// Signals:
//   i_pll_locked      PLL lock, asynchronous to the reference clock
//   i_restart         single-cycle software restart request
//   o_pll_reset       active-high PLL reset
//   o_domain_rst_n    active-low per-domain resets, bit 0 released first
//   o_ready           all domains released and lock good
//   o_fault           retries exhausted
//   o_retry_count     failed lock attempts in the current sequence
//   o_lock_loss_count saturating lock-loss count (RELEASE/RUN only)
//   o_state           sequencer state code
interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int RC_W        = 3
);
  logic                   i_pll_locked;
  logic                   i_restart;
  logic                   o_pll_reset;
  logic [NUM_DOMAINS-1:0] o_domain_rst_n;
  logic                   o_ready;
  logic                   o_fault;
  logic [RC_W-1:0]        o_retry_count;
  logic [7:0]             o_lock_loss_count;
  logic [2:0]             o_state;

  modport master (
    output i_pll_locked, i_restart,
    input  o_pll_reset, o_domain_rst_n, o_ready, o_fault,
           o_retry_count, o_lock_loss_count, o_state
  );

  modport slave (
    input  i_pll_locked, i_restart,
    output o_pll_reset, o_domain_rst_n, o_ready, o_fault,
           o_retry_count, o_lock_loss_count, o_state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock / reset-tree sequencer. Runs on the free-running
// reference clock. Holds the PLL in reset, qualifies lock with a timeout and
// bounded retries, then releases domain resets in order with a fixed gap.
// Ports:
//   i_clk   free-running reference clock
//   i_rst_n asynchronous active-low reset
//   bus     pll_reset_sequencer_if.slave (lock/restart in, resets/status out)
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int NUM_DOMAINS        = 3,
  parameter int RELEASE_GAP        = 8,
  parameter int MAX_RETRIES        = 4,
  parameter int RC_W               = $clog2(MAX_RETRIES + 1)
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int HOLD_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(NUM_DOMAINS * RELEASE_GAP + 2);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(NUM_DOMAINS * RELEASE_GAP);
  localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_HOLD  = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_RELEASE     = 3'd3,
    S_RUN         = 3'd4,
    S_FAULT       = 3'd5
  } state_e;

  state_e                 state_q;
  logic [1:0]             sync_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [TMR_W-1:0]       tmr_q;
  logic [STAB_W-1:0]      stab_q;
  logic [GAP_W-1:0]       gap_q;
  logic [RC_W-1:0]        retry_q;
  logic [7:0]             loss_q;
  logic                   pll_reset_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic                   fault_q;

  logic                   locked_s;
  logic                   lock_lost;
  logic [RC_W-1:0]        retry_d;
  logic [7:0]             loss_d;
  logic [NUM_DOMAINS-1:0] rel_d;

  assign locked_s  = sync_q[1];
  assign lock_lost = !locked_s && (state_q == S_RELEASE || state_q == S_RUN);
  assign retry_d   = retry_q + RC_W'(1);
  assign loss_d    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

  // Domain k is released on the edge where the in-RELEASE cycle count reaches
  // (k+1)*RELEASE_GAP, so the registered bit is high from that cycle on.
  always_comb begin
    rel_d = '0;
    for (int k = 0; k < NUM_DOMAINS; k++)
      rel_d[k] = (int'(gap_q) + 1) >= (k + 1) * RELEASE_GAP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RESET_HOLD;
      sync_q      <= '0;
      hold_q      <= '0;
      tmr_q       <= '0;
      stab_q      <= '0;
      gap_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.i_pll_locked};
      // Loss is counted even when a restart lands in the same cycle.
      if (lock_lost) loss_q <= loss_d;

      if (bus.i_restart || lock_lost) begin
        state_q     <= S_RESET_HOLD;
        hold_q      <= '0;
        pll_reset_q <= 1'b1;
        dom_q       <= '0;
        ready_q     <= 1'b0;
        if (bus.i_restart) begin
          retry_q <= '0;
          fault_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_RESET_HOLD: begin
            if (hold_q == HOLD_LAST) begin
              state_q     <= S_WAIT_LOCK;
              pll_reset_q <= 1'b0;
              tmr_q       <= '0;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          S_WAIT_LOCK, S_LOCK_STABLE: begin
            // One timer spans the whole attempt, so lock chatter between
            // WAIT_LOCK and LOCK_STABLE cannot extend it.
            if (tmr_q == TMR_LAST) begin
              retry_q     <= retry_d;
              hold_q      <= '0;
              pll_reset_q <= 1'b1;
              if (retry_d == RC_MAX) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
              end else begin
                state_q <= S_RESET_HOLD;
              end
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
              if (state_q == S_WAIT_LOCK) begin
                if (locked_s) begin
                  state_q <= S_LOCK_STABLE;
                  stab_q  <= '0;
                end
              end else if (!locked_s) begin
                state_q <= S_WAIT_LOCK;
              end else if (stab_q == STAB_LAST) begin
                state_q <= S_RELEASE;
                gap_q   <= '0;
              end else begin
                stab_q <= stab_q + STAB_W'(1);
              end
            end
          end
          S_RELEASE: begin
            dom_q <= rel_d;
            if (gap_q == GAP_LAST) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          S_RUN, S_FAULT: ;
          default: begin
            state_q     <= S_RESET_HOLD;
            hold_q      <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            ready_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_pll_reset       = pll_reset_q;
  assign bus.o_domain_rst_n    = dom_q;
  assign bus.o_ready           = ready_q;
  assign bus.o_fault           = fault_q;
  assign bus.o_retry_count     = retry_q;
  assign bus.o_lock_loss_count = loss_q;
  assign bus.o_state           = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the board PLL (200 MHz reference in; 166.67 / 666.67 / 200 MHz out) and its downstream reset tree.
- Holds the PLL in reset for a minimum time after power-up, waits for a stable lock with a timeout and bounded retries, then releases per-domain resets in a fixed order.
- Re-sequences on loss of lock or on a software restart request.
- Runs on the free-running 200 MHz reference clock, never on a PLL output.

Parameters:
- PLL_RST_CYCLES, 16, cycles o_pll_reset is held high per attempt
- LOCK_TIMEOUT, 65536, max cycles from PLL reset release to qualified lock before a retry
- LOCK_STABLE_CYCLES, 256, consecutive synced-lock cycles needed to qualify lock
- NUM_DOMAINS, 3, number of downstream reset outputs
- RELEASE_GAP, 8, cycles between successive domain reset releases
- MAX_RETRIES, 4, failed attempts before entering FAULT

Ports:
- i_clk  in  1  free-running reference clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pll_locked  in  1  PLL locked, asynchronous to i_clk
- i_restart  in  1  single-cycle restart request
- o_pll_reset  out  1  active-high PLL reset
- o_domain_rst_n  out  NUM_DOMAINS  active-low domain resets; index 0 is released first
- o_ready  out  1  all domains out of reset, lock good
- o_fault  out  1  retries exhausted
- o_retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence
- o_lock_loss_count  out  8  saturating count of lock losses during RELEASE or RUN
- o_state  out  3  0 RESET_HOLD, 1 WAIT_LOCK, 2 LOCK_STABLE, 3 RELEASE, 4 RUN, 5 FAULT

Behaviour:
- All outputs are registered.
- Reset values:
  - state RESET_HOLD
  - o_pll_reset=1, o_domain_rst_n=0, o_ready=0, o_fault=0
  - both counts 0; all internal counters 0
- i_pll_locked passes through a 2-FF synchronizer (reset to 0) to give locked_s; 2-cycle latency. Only locked_s is used.
- o_pll_reset=1 only in RESET_HOLD and FAULT.
- o_domain_rst_n is all 0 in every state except RELEASE and RUN.
- RESET_HOLD:
  - Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
  - The attempt timer clears on entry to WAIT_LOCK.
- Attempt timer:
  - Counts every cycle in WAIT_LOCK and LOCK_STABLE.
  - If it reaches LOCK_TIMEOUT-1 in either state, the attempt fails: retry_count increments.
  - If the new retry_count equals MAX_RETRIES, go to FAULT; otherwise go to RESET_HOLD.
- WAIT_LOCK: locked_s=1 → LOCK_STABLE, stable counter cleared.
- LOCK_STABLE:
  - locked_s=0 → WAIT_LOCK; the attempt timer is NOT cleared, so a chattering lock still times out.
  - LOCK_STABLE_CYCLES consecutive cycles of locked_s=1 → RELEASE, gap counter cleared.
- RELEASE:
  - o_domain_rst_n[k] goes high at cycle (k+1)*RELEASE_GAP after entry.
  - The cycle after the last bit goes high: go to RUN, o_ready=1, retry_count cleared.
- Lock loss in RELEASE or RUN (locked_s=0):
  - Next cycle: o_domain_rst_n=0, o_ready=0, o_lock_loss_count increments (saturates at 255), state RESET_HOLD.
- FAULT:
  - o_fault=1; PLL and all domains held in reset.
  - Exits only on i_restart or i_rst_n.
- i_restart in any state:
  - Next cycle: state RESET_HOLD, retry_count=0, o_fault=0, o_ready=0, domains in reset, RESET_HOLD counter restarted.
  - Restart has priority over timeout and stable-qualify transitions in the same cycle.
  - If restart coincides with a lock loss in RELEASE or RUN, the loss count still increments.
- Reset mid-operation: asynchronous return to the reset values in every state.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, RELEASE_GAP=2, NUM_DOMAINS=3, MAX_RETRIES=2):
- Nominal:
  - Stimulus: release i_rst_n; i_pll_locked rises 5 cycles after o_pll_reset falls.
  - Response: o_pll_reset high for exactly 4 cycles; o_domain_rst_n steps 001, 011, 111 at 2-cycle spacing after 8 stable cycles; o_ready=1 one cycle after 111; o_retry_count=0.
- Chatter then timeout:
  - Stimulus: lock toggles every 5 cycles.
  - Response: never reaches RELEASE; after 32 cycles o_retry_count=1 and o_pll_reset re-asserts for 4 cycles.
- Fault:
  - Stimulus: lock held 0.
  - Response: after the second timeout, o_state=5, o_fault=1, o_pll_reset=1, o_domain_rst_n=000.
  - Then: i_restart pulse → o_fault=0, o_retry_count=0, o_state=0.
- Loss in RUN:
  - Stimulus: drop lock while o_ready=1.
  - Response: 2 sync cycles, then next cycle o_domain_rst_n=000, o_ready=0, o_lock_loss_count=1.
  - Then: re-lock → full sequence repeats.
- Restart during RELEASE:
  - Stimulus: i_restart when o_domain_rst_n=001.
  - Response: next cycle o_domain_rst_n=000, o_state=0, o_lock_loss_count unchanged.
- Async reset mid-RELEASE:
  - Stimulus: assert i_rst_n low.
  - Response: all outputs immediately at reset values without a clock edge; lock loss counter saturation checked separately (256 forced losses → 255).
